// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch stage. Issues one word read at a time to
//                instruction memory, presents fetched words to decode, holds
//                one word in a skid buffer while decode stalls, and redirects
//                on decode jumps or execute-stage mispredict corrections.
//                Reads that are in flight when a redirect lands are drained
//                and their data discarded.
//  Ports       : clk, rst_n (async, active-low)
//                imem_re/imem_addr/imem_rdy/imem_data - memory read port
//                instr/i_addr/instr_valid             - word to decode
//                stall                                - decode back-pressure
//                jump/J_sel/new_PC/reg_target         - decode redirect
//                mispredict/fix_PC                    - execute redirect
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_re,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic [15:0] i_addr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        jump,
    input  logic        J_sel,
    input  logic [15:0] new_PC,
    input  logic [15:0] reg_target,
    input  logic        mispredict,
    input  logic [15:0] fix_PC
);

    localparam logic [15:0] C_NOP = 16'hF000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_buf_data;
    logic [15:0] r_buf_addr;
    logic [15:0] r_instr;
    logic [15:0] r_i_addr;
    logic        r_valid;

    logic        w_jump_acc;
    logic        w_redirect;
    logic [15:0] w_target;

    // A jump only counts against a real word that decode is consuming this
    // cycle; a simultaneous mispredict overrides it.
    assign w_jump_acc = jump & r_valid & ~stall & ~mispredict;
    assign w_redirect = mispredict | w_jump_acc;
    assign w_target   = mispredict ? fix_PC : (J_sel ? reg_target : new_PC);

    // Request is gated by rst_n so nothing is issued while reset is held,
    // yet the first request appears in the very cycle reset is released.
    assign imem_re     = rst_n & (r_state == FETCH);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign i_addr      = r_i_addr;
    assign instr_valid = r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FETCH;
            r_pc       <= 16'h0000;
            r_buf_data <= 16'h0000;
            r_buf_addr <= 16'h0000;
            r_instr    <= C_NOP;
            r_i_addr   <= 16'h0000;
            r_valid    <= 1'b0;
        end else if (w_redirect) begin
            r_pc       <= w_target;
            r_buf_data <= 16'h0000;
            r_buf_addr <= 16'h0000;
            r_instr    <= C_NOP;
            r_valid    <= 1'b0;
            case (r_state)
                // A read still in flight must be drained before the new
                // target is requested, keeping one outstanding read at most.
                FETCH:   r_state <= imem_rdy ? FETCH : DRAIN;
                FULL:    r_state <= FETCH;
                DRAIN:   r_state <= imem_rdy ? FETCH : DRAIN;
                default: r_state <= FETCH;
            endcase
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_rdy) begin
                        r_pc <= r_pc + 16'd1;
                        if (!stall) begin
                            r_instr  <= imem_data;
                            r_i_addr <= r_pc;
                            r_valid  <= 1'b1;
                        end else begin
                            // Decode is busy: park the word, outputs hold.
                            r_buf_data <= imem_data;
                            r_buf_addr <= r_pc;
                            r_state    <= FULL;
                        end
                    end else if (!stall) begin
                        // Decode took the current word and nothing replaces it.
                        r_instr <= C_NOP;
                        r_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        r_instr  <= r_buf_data;
                        r_i_addr <= r_buf_addr;
                        r_valid  <= 1'b1;
                        r_state  <= FETCH;
                    end
                end
                DRAIN: begin
                    // Stale word returns and is dropped; fetch_pc already
                    // holds the redirect target.
                    if (imem_rdy) begin
                        r_state <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have clock input clk, 1 bit; all state updates on its rising edge.
REQ-002 SHALL have reset input rst_n, 1 bit; reset is asynchronous and active-low.
REQ-003 SHALL have imem_re, output, 1 bit: instruction-memory read request.
REQ-004 SHALL have imem_addr, output, 16 bits: word address of the outstanding read.
REQ-005 SHALL have imem_rdy, input, 1 bit: read data valid this cycle.
REQ-006 SHALL have imem_data, input, 16 bits: read data.
REQ-007 SHALL have instr, output, 16 bits: instruction word to decode.
REQ-008 SHALL have i_addr, output, 16 bits: address of instr.
REQ-009 SHALL have instr_valid, output, 1 bit: instr holds a real fetched word.
REQ-010 SHALL have stall, input, 1 bit: decode cannot accept; hold instr/i_addr/instr_valid.
REQ-011 SHALL have jump, input, 1 bit: decode redirect request for the current instr.
REQ-012 SHALL have J_sel, input, 1 bit: 1 selects reg_target, 0 selects new_PC.
REQ-013 SHALL have new_PC, input, 16 bits: PC-relative redirect target.
REQ-014 SHALL have reg_target, input, 16 bits: register-indirect redirect target.
REQ-015 SHALL have mispredict, input, 1 bit: execute-stage branch correction.
REQ-016 SHALL have fix_PC, input, 16 bits: corrected target.

Function
REQ-017 SHALL hold a 16-bit fetch_pc; increment is modulo 2^16 (16'hFFFF+1 = 16'h0000).
REQ-018 SHALL implement states FETCH, FULL, DRAIN.
REQ-019 FETCH: imem_re=1 and imem_addr=fetch_pc; address held stable until imem_rdy.
REQ-020 FETCH, imem_rdy=1, stall=0, no redirect: next cycle instr=imem_data, i_addr=fetch_pc, instr_valid=1; fetch_pc+1; stay FETCH.
REQ-021 FETCH, imem_rdy=1, stall=1, no redirect: capture imem_data/fetch_pc in a 1-entry buffer; fetch_pc+1; go FULL; outputs unchanged.
REQ-022 FULL: imem_re=0; when stall=0, buffer moves to instr/i_addr with instr_valid=1 next cycle; go FETCH.
REQ-023 FETCH, stall=0, instr_valid=0 and no imem_rdy: instr_valid stays 0 and instr=16'hF000 (no-op opcode).
REQ-024 Jump redirect SHALL be accepted only when jump=1, instr_valid=1, stall=0; target = J_sel ? reg_target : new_PC.
REQ-025 Mispredict redirect SHALL be accepted whenever mispredict=1, regardless of stall; target = fix_PC.
REQ-026 Mispredict and jump in the same cycle: mispredict wins; jump ignored.
REQ-027 On accepted redirect: fetch_pc=target, buffer cleared, next cycle instr_valid=0 and instr=16'hF000.
REQ-028 Redirect while a read is outstanding without imem_rdy that cycle: go DRAIN; imem_re=0.
REQ-029 Redirect in the same cycle as imem_rdy: returned word discarded; go FETCH directly.
REQ-030 Redirect in FULL: buffer discarded; go FETCH.
REQ-031 DRAIN: imem_re=0; on imem_rdy the word is discarded and state goes FETCH at target.
REQ-032 A second redirect in DRAIN SHALL overwrite fetch_pc; state remains DRAIN.
REQ-033 SHALL have at most one outstanding memory read at any time.

Reset
REQ-034 While rst_n=0: fetch_pc=16'h0000, instr=16'hF000, i_addr=16'h0000, instr_valid=0, buffer empty, state FETCH.
REQ-035 While rst_n=0, imem_re SHALL be 0; first request is issued in the first cycle after rst_n rises.
REQ-036 Reset asserted mid-request or mid-DRAIN SHALL abandon it; a late imem_rdy after reset SHALL be accepted as the response to the new address-0 request only if imem_re was asserted.

Verification
REQ-037 Reset release, imem_rdy 1 cycle after each request, data 16'h0123,16'h1456 -> instr 0123 @i_addr 0000 then 1456 @0001, instr_valid=1.
REQ-038 stall=1 for 3 cycles as word @0005 returns -> state FULL, imem_re=0, outputs frozen; stall drop -> instr @0005 next cycle, fetch resumes @0006.
REQ-039 jump=1, J_sel=0, new_PC=16'h0040 while imem read @0008 pending 3 cycles -> DRAIN, pending word discarded, next request @0040, bubble instr=F000.
REQ-040 mispredict=1 fix_PC=16'h0100 with jump=1 J_sel=1 reg_target=16'h0200 and stall=1 -> next fetch @0100, instr_valid=0.
REQ-041 fetch_pc=16'hFFFF fetched, no redirect -> next imem_addr=16'h0000.
REQ-042 rst_n low during pending read @0030 -> outputs reset values immediately; after release request @0000.
